// File: rtl/obi_uart_if.sv
// OBI slave-port bundle for obi_uart: request/grant, address phase and response phase.
interface obi_uart_if;
    logic        req_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/obi_uart.sv
// OBI slave UART: 8N1 TX with FIFO, RX with holding register or FIFO, programmable baud divider.
// Define UART_RX_FIFO_EN to give the receive path a FIFO_DEPTH-entry FIFO instead of one holding register.
module obi_uart #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic      clk_i,
    input  logic      rst_i,
    obi_uart_if.slave bus,
    output logic      uart_tx_o,
    input  logic      uart_rx_i,
    output logic      irq_o
);
    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    // A divider below 2 would leave no room for the half-bit start sample.
    function automatic logic [15:0] sat_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

    logic [2:0]  sel;
    logic        wr, rd;
    logic        ctrl_wr, stat_wr, baud_wr, txd_wr, rxd_rd;
    logic [3:0]  ctrl;
    logic [15:0] baud, baud_new;
    logic        rx_overrun, frame_err;
    logic        rvalid_p1;
    logic [31:0] rdata_p1, rd_val;
    logic        unused_bits;

    assign sel     = bus.addr_i[4:2];
    assign wr      = bus.req_i & bus.we_i;
    assign rd      = bus.req_i & ~bus.we_i;
    assign ctrl_wr = wr & (sel == 3'd0) & bus.be_i[0];
    assign stat_wr = wr & (sel == 3'd1) & bus.be_i[0];
    assign baud_wr = wr & (sel == 3'd2) & (|bus.be_i[1:0]);
    assign txd_wr  = wr & (sel == 3'd3) & bus.be_i[0];
    assign rxd_rd  = rd & (sel == 3'd4);

    assign unused_bits = ^{bus.addr_i[31:5], bus.addr_i[1:0], bus.wdata_i[31:16], bus.be_i[3:2]};

    assign baud_new = {bus.be_i[1] ? bus.wdata_i[15:8] : baud[15:8],
                       bus.be_i[0] ? bus.wdata_i[7:0]  : baud[7:0]};

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [AW:0]   tx_level;
    logic          tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]    tx_head;

    assign tx_full  = (tx_level == DEPTH_C);
    assign tx_empty = (tx_level == '0);
    assign tx_push  = txd_wr & (~tx_full | tx_pop);
    assign tx_head  = tx_mem[tx_rptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + 1'b1;
                2'b01:   tx_level <= tx_level - 1'b1;
                default: tx_level <= tx_level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr] <= bus.wdata_i[7:0];
    end

    // ---------------- TX state machine ----------------
    uart_state_e tx_state, tx_state_n;
    logic [15:0] tx_tmr, tx_tmr_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_line, tx_line_n, tx_tick;

    assign tx_tick = (tx_tmr == tx_div - 16'd1);

    always_comb begin
        tx_state_n = tx_state;
        tx_tmr_n   = tx_tmr + 16'd1;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_line_n = 1'b1;
                tx_tmr_n  = '0;
                if (ctrl[0] && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_line_n  = 1'b0;
                    tx_div_n   = baud;
                    tx_state_n = S_START;
                end
            end
            S_START: if (tx_tick) begin
                tx_tmr_n   = '0;
                tx_div_n   = baud;
                tx_bit_n   = '0;
                tx_line_n  = tx_shift[0];
                tx_state_n = S_DATA;
            end
            S_DATA: if (tx_tick) begin
                tx_tmr_n = '0;
                tx_div_n = baud;
                if (tx_bit == 3'd7) begin
                    tx_line_n  = 1'b1;
                    tx_state_n = S_STOP;
                end else begin
                    tx_bit_n   = tx_bit + 3'd1;
                    tx_shift_n = tx_shift >> 1;
                    tx_line_n  = tx_shift[1];
                end
            end
            S_STOP: if (tx_tick) begin
                tx_tmr_n   = '0;
                tx_state_n = S_IDLE;
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state <= S_IDLE;
            tx_tmr   <= '0;
            tx_div   <= DEFAULT_DIV;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tmr   <= tx_tmr_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_line  <= tx_line_n;
        end
    end

    always_ff @(posedge clk_i) tx_shift <= tx_shift_n;

    assign uart_tx_o = tx_line;

    // ---------------- RX synchronizer and state machine ----------------
    logic        rx_s1, rx_s2, rx_prev, rx_fall;
    uart_state_e rx_state, rx_state_n;
    logic [15:0] rx_tmr, rx_tmr_n, rx_div, rx_div_n, rx_lim;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_push, fe_set, rx_tick;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_lim  = (rx_state == S_START) ? ({1'b0, rx_div[15:1]} - 16'd1) : (rx_div - 16'd1);
    assign rx_tick = (rx_tmr == rx_lim);

    always_comb begin
        rx_state_n = rx_state;
        rx_tmr_n   = rx_tmr + 16'd1;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        if (!ctrl[1]) begin
            rx_state_n = S_IDLE;
            rx_tmr_n   = '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_tmr_n = '0;
                    if (rx_fall) begin
                        rx_div_n   = baud;
                        rx_state_n = S_START;
                    end
                end
                // Mid-start-bit check rejects glitches shorter than half a bit.
                S_START: if (rx_tick) begin
                    rx_tmr_n   = '0;
                    rx_div_n   = baud;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_tick) begin
                    rx_tmr_n   = '0;
                    rx_div_n   = baud;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                end
                S_STOP: if (rx_tick) begin
                    rx_tmr_n   = '0;
                    rx_push    = rx_s2;
                    fe_set     = ~rx_s2;
                    rx_state_n = S_IDLE;
                end
                default: rx_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state <= S_IDLE;
            rx_tmr   <= '0;
            rx_div   <= DEFAULT_DIV;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_tmr   <= rx_tmr_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
        end
    end

    always_ff @(posedge clk_i) rx_shift <= rx_shift_n;

    // ---------------- RX buffer ----------------
    logic       rx_full, rx_nempty, rx_pop, rx_wr, ovr_set;
    logic [7:0] rx_head;

    assign rx_pop  = rxd_rd & rx_nempty;
    assign rx_wr   = rx_push & (~rx_full | rx_pop);
    assign ovr_set = rx_push & rx_full & ~rx_pop;

`ifdef UART_RX_FIFO_EN
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [AW:0]   rx_level;

    assign rx_full   = (rx_level == DEPTH_C);
    assign rx_nempty = (rx_level != '0);
    assign rx_head   = rx_mem[rx_rptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_level <= '0;
        end else begin
            if (rx_wr)  rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
            case ({rx_wr, rx_pop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: rx_level <= rx_level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_wr) rx_mem[rx_wptr] <= rx_shift;
    end
`else
    logic [7:0] rx_hold;
    logic       rx_valid;

    assign rx_full   = rx_valid;
    assign rx_nempty = rx_valid;
    assign rx_head   = rx_hold;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rx_valid <= 1'b0;
        else       rx_valid <= rx_wr | (rx_valid & ~rx_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rx_wr) rx_hold <= rx_shift;
    end
`endif

    // ---------------- Registers and bus response ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl       <= '0;
            baud       <= DEFAULT_DIV;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= bus.wdata_i[3:0];
            if (baud_wr) baud <= sat_div(baud_new);
            rx_overrun <= (rx_overrun & ~(stat_wr & bus.wdata_i[3])) | ovr_set;
            frame_err  <= (frame_err  & ~(stat_wr & bus.wdata_i[4])) | fe_set;
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            3'd0:    rd_val[3:0]  = ctrl;
            3'd1:    rd_val[5:0]  = {tx_state != S_IDLE, frame_err, rx_overrun,
                                     rx_nempty, tx_empty, tx_full};
            3'd2:    rd_val[15:0] = baud;
            3'd4:    rd_val[7:0]  = rx_nempty ? rx_head : 8'h00;
            default: rd_val       = '0;
        endcase
    end

    // ---- response stage p1: one cycle after the grant edge ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_p1 <= 1'b0;
            rdata_p1  <= '0;
        end else begin
            rvalid_p1 <= bus.req_i;
            rdata_p1  <= rd ? rd_val : 32'h0;
        end
    end

    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = rvalid_p1;
    assign bus.rdata_o  = rdata_p1;

    assign irq_o = (rx_nempty & ctrl[2]) | (tx_empty & ctrl[3]);
endmodule

// File: tb/tb_obi_uart.sv
// Directed self-checking bench for obi_uart (default parameters, BAUD reprogrammed to 4/8).
module tb_obi_uart;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obi_uart_if bus();
    logic rx_drv  = 1'b1;
    logic loop_en = 1'b0;
    logic tx_pin, rx_pin, irq;
    assign rx_pin = loop_en ? tx_pin : rx_drv;

    obi_uart dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus),
        .uart_tx_o(tx_pin),
        .uart_rx_i(rx_pin),
        .irq_o    (irq)
    );

`ifdef UART_RX_FIFO_EN
    localparam int RXD = 8;
`else
    localparam int RXD = 1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d; bus.be_i = b;
        #1 chk("wr_gnt", bus.gnt_o, 1);
        @(posedge clk);
        #1;
        bus.req_i = 1'b0; bus.we_i = 1'b0;
        chk("wr_rvalid", bus.rvalid_o, 1);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.be_i = 4'h0;
        #1 chk("rd_gnt", bus.gnt_o, 1);
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        chk("rd_rvalid", bus.rvalid_o, 1);
        d = bus.rdata_o;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        chk(tag, d, exp);
    endtask

    // Drives one 8-cycle-per-bit frame on the RX pin, then 16 idle cycles.
    task automatic inject(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (8) @(negedge clk);
        end
        rx_drv = stop;
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [9:0]  frm;
        logic        line [40];
        logic        prev;
        int          falls;

        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.be_i = '0; bus.wdata_i = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_pin, 1);
        chk("rst_rvalid", bus.rvalid_o, 0);
        chk("rst_rdata", bus.rdata_o, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b0;

        rd_chk("ctrl_rst", 32'h00, 32'h0);
        rd_chk("status_rst", 32'h04, 32'h02);
        rd_chk("baud_rst", 32'h08, 32'd434);
        rd_chk("txdata_rd", 32'h0C, 32'h0);
        rd_chk("rxdata_empty", 32'h10, 32'h0);
        rd_chk("unmapped_rd", 32'h14, 32'h0);
        @(posedge clk); #1;
        chk("rvalid_drop", bus.rvalid_o, 0);

        // BAUD saturation and byte lanes
        bus_wr(32'h08, 32'h0, 4'hF);
        rd_chk("baud_sat0", 32'h08, 32'd2);
        bus_wr(32'h08, 32'h0000_0100, 4'b0010);
        rd_chk("baud_lane1", 32'h08, 32'h0102);
        bus_wr(32'h08, 32'h1, 4'hF);
        rd_chk("baud_sat1", 32'h08, 32'd2);
        bus_wr(32'h14, 32'hFFFF_FFFF, 4'hF);
        rd_chk("ctrl_after_unmapped", 32'h00, 32'h0);
        bus_wr(32'h08, 32'd4, 4'hF);
        bus_wr(32'h00, 32'h1, 4'b0000);
        rd_chk("ctrl_be_gate", 32'h00, 32'h0);

        // TX frame 0xA5 at BAUD=4
        bus_wr(32'h00, 32'h1, 4'hF);
        bus_wr(32'h0C, 32'hA5, 4'h1);
        chk("tx_lat0", tx_pin, 1);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            line[k] = tx_pin;
        end
        frm = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) chk("tx_a5_bit", line[k], frm[k / 4]);
        repeat (4) @(posedge clk);

        // tx_busy during a frame
        bus_wr(32'h0C, 32'h00, 4'h1);
        rd_chk("status_pre_start", 32'h04, 32'h00);
        rd_chk("status_busy", 32'h04, 32'h22);
        repeat (45) @(posedge clk);
        rd_chk("status_done", 32'h04, 32'h02);

        // TX FIFO fill with tx_en=0, then drain
        bus_wr(32'h00, 32'h0, 4'hF);
        for (int i = 0; i < 10; i++) bus_wr(32'h0C, 32'hFF, 4'h1);
        rd_chk("tx_full", 32'h04, 32'h01);
        bus_wr(32'h00, 32'h1, 4'hF);
        falls = 0;
        prev  = tx_pin;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (prev && !tx_pin) falls++;
            prev = tx_pin;
        end
        chk("tx_frames", falls, 8);
        rd_chk("tx_drained", 32'h04, 32'h02);

        // Loopback receive of 0x3C at BAUD=8
        bus_wr(32'h08, 32'd8, 4'h3);
        loop_en = 1'b1;
        bus_wr(32'h00, 32'h3, 4'hF);
        bus_wr(32'h0C, 32'h3C, 4'h1);
        repeat (120) @(posedge clk);
        rd_chk("loop_status", 32'h04, 32'h06);
        rd_chk("loop_rxdata", 32'h10, 32'h3C);
        rd_chk("loop_popped", 32'h04, 32'h02);
        loop_en = 1'b0;

        // tx_empty interrupt
        bus_wr(32'h00, 32'h8, 4'hF);
        chk("irq_tx_empty", irq, 1);
        bus_wr(32'h00, 32'h2, 4'hF);
        chk("irq_off", irq, 0);

        // Framing error, W1C with and without byte enable
        inject(8'h55, 1'b0);
        rd_chk("frame_err", 32'h04, 32'h12);
        bus_wr(32'h04, 32'h10, 4'h0);
        rd_chk("fe_be_gated", 32'h04, 32'h12);
        bus_wr(32'h04, 32'h10, 4'h1);
        rd_chk("fe_cleared", 32'h04, 32'h02);

        // Start-bit glitch is rejected
        @(negedge clk); rx_drv = 1'b0;
        repeat (2) @(negedge clk); rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        rd_chk("glitch", 32'h04, 32'h02);

        // Overrun: RXD bytes kept, one more discarded
        bus_wr(32'h00, 32'h6, 4'hF);
        chk("irq_rx_idle", irq, 0);
        for (int i = 0; i <= RXD; i++) inject(8'h30 + 8'(i), 1'b1);
        rd_chk("overrun", 32'h04, 32'h0E);
        chk("irq_rx", irq, 1);
        for (int i = 0; i < RXD; i++) rd_chk("rx_order", 32'h10, 32'h30 + i);
        rd_chk("ovr_sticky", 32'h04, 32'h0A);
        rd_chk("rx_empty_rd", 32'h10, 32'h0);
        bus_wr(32'h04, 32'h08, 4'h1);
        rd_chk("ovr_cleared", 32'h04, 32'h02);
        chk("irq_rx_off", irq, 0);

        // Asynchronous reset mid-frame
        bus_wr(32'h08, 32'd4, 4'h3);
        bus_wr(32'h00, 32'h1, 4'hF);
        bus_wr(32'h0C, 32'h00, 4'h1);
        @(posedge clk); #1;
        chk("pre_rst_start", tx_pin, 0);
        #2 rst = 1'b1;
        #1 chk("async_rst_tx", tx_pin, 1);
        @(negedge clk); rst = 1'b0;
        rd_chk("baud_rerst", 32'h08, 32'd434);
        rd_chk("status_rerst", 32'h04, 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/obi_uart.md
# obi_uart

OBI slave UART peripheral on one slave port of the SoC OBI interconnect, driving the `uart_tx_pin`/`uart_rx_pin` pads. It provides 8N1 serial transmit and receive with a programmable baud divider and a transmit FIFO. The receive path has an optional FIFO. Status flags and data registers are memory-mapped at word offsets below the slave base address.

## Interface
- `FIFO_DEPTH`, default 8: TX FIFO depth, and RX FIFO depth when enabled. Power of two, ≥2.
- `DEFAULT_DIV`, default 16'd434: reset value of BAUD; clocks per bit.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in 1: OBI request.
- `gnt_o` out 1: OBI grant.
- `rvalid_o` out 1: OBI response valid.
- `addr_i` in 32: byte address; only bits [4:2] are decoded.
- `we_i` in 1: write enable.
- `be_i` in 4: byte enables.
- `wdata_i` in 32: write data.
- `rdata_o` out 32: read data, valid while `rvalid_o`=1.
- `uart_tx_o` out 1: serial out, idle high.
- `uart_rx_i` in 1: serial in, asynchronous to `clk_i`.
- `irq_o` out 1: level interrupt, `(rx_nempty & CTRL[2]) | (tx_empty & CTRL[3])`.

## Operation
- Register map (offsets 0x00–0x10):
  - 0x00 CTRL, RW: [0] tx_en, [1] rx_en, [2] rx_irq_en, [3] tx_irq_en. Reset 0.
  - 0x04 STATUS, RO except where noted: [0] tx_full, [1] tx_empty, [2] rx_nempty, [3] rx_overrun (sticky, W1C), [4] frame_err (sticky, W1C), [5] tx_busy.
  - 0x08 BAUD, RW: [15:0] divider. Writes of 0 or 1 are stored as 2.
  - 0x0C TXDATA, WO: [7:0] pushes one byte to the TX FIFO. The write is dropped silently when the FIFO is full. Reads return 0.
  - 0x10 RXDATA, RO: [7:0] returns the head byte and pops it. When empty, returns 0 and does not pop.
  - Other offsets: reads return 0; writes are ignored.
- Byte enables: `be_i[0]` gates TXDATA and CTRL. `be_i[1:0]` gate BAUD byte lanes. Reads ignore `be_i`.
- TX state machine IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE.
  - Each state or bit lasts BAUD cycles.
  - Leaves IDLE only when tx_en=1 and the FIFO is not empty; the byte is popped on entry to START.
  - Clearing tx_en mid-frame finishes the current frame.
- RX path:
  - 2-flop synchronizer on `uart_rx_i`; nothing is sampled while rx_en=0.
  - State machine IDLE→START→DATA→STOP.
  - A falling edge in IDLE starts a half-bit count (BAUD>>1). If the line is still low, proceed; otherwise return to IDLE (glitch).
  - Data bits are sampled every BAUD cycles after that point.
  - STOP sample = 0: set frame_err and discard the byte.
  - STOP sample = 1: push the byte. If the FIFO is full, set rx_overrun and discard the new byte.
- Simultaneous events:
  - RX push and RXDATA pop in the same cycle: both take effect (count unchanged).
  - W1C and a hardware set of the same flag in the same cycle: the set wins.
  - TX push and pop in the same cycle on a full FIFO: push accepted.
- Reset: all FSMs to IDLE, FIFOs emptied, sticky flags cleared, BAUD=DEFAULT_DIV.

## Timing
- `gnt_o` = `req_i` combinationally; there are no wait states.
- `rvalid_o` asserts exactly one cycle after each granted request, reads and writes alike.
- `rdata_o` is registered; it holds 0 whenever `rvalid_o`=0.
- Register write effects, FIFO push and FIFO pop occur at the grant edge.
  - STATUS read back in the next transaction reflects them.
  - Back-to-back requests are supported at one per cycle.
- Reset values: `gnt_o` follows `req_i`, `rvalid_o`=0, `rdata_o`=0, `uart_tx_o`=1, `irq_o`=0.
- TX latency: `uart_tx_o` falls 1 cycle after the TXDATA grant edge when idle and tx_en=1. A frame is 10×BAUD cycles.
- RX latency: rx_nempty rises 2 (sync) + 0.5×BAUD + 9×BAUD + 1 cycles after the start-bit falling edge.
- A BAUD change takes effect at the next bit boundary.
- Reset asserted mid-frame forces `uart_tx_o`=1 asynchronously.

## Configuration
- `UART_RX_FIFO_EN` defined: the RX buffer is a FIFO of FIFO_DEPTH entries.
- Not defined: the RX buffer is a single holding register (depth 1), and overrun is flagged on the second unread byte. The register map is unchanged.

## Test plan
- Reset, then read all registers: CTRL=0, STATUS=0x02, BAUD=434, `uart_tx_o`=1, `rvalid_o` one cycle after each `req_i`.
- BAUD=4, CTRL=1, write TXDATA=0xA5: the line shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 4 cycles; tx_busy during the frame.
- Loop `uart_tx_o` to `uart_rx_i`, BAUD=8, CTRL=3, send 0x3C: RXDATA reads 0x3C, then STATUS[2]=0.
- Write FIFO_DEPTH+2 bytes with tx_en=0: tx_full=1 and the extra bytes are dropped; set tx_en: exactly FIFO_DEPTH frames transmitted.
- Inject a byte with stop bit 0: frame_err=1 and rx_nempty=0; write STATUS=0x10: frame_err clears.
- Inject FIFO_DEPTH+1 bytes without reading: rx_overrun=1 and the first FIFO_DEPTH bytes are preserved in order. Without the macro, overrun occurs after the 2nd byte.
